// File: rtl/chunked_addsub_seq.sv
// Purpose: multi-cycle two's-complement add/subtract, CHUNK bits per cycle with a registered carry.
// Latency: the operand-accept edge is cycle 0; out_valid rises after edge NCHUNK (= WIDTH/CHUNK).
// Backpressure: one op in flight; in_ready only in IDLE; the result is held in DONE until out_ready.
//
// Ports:
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   in_valid / in_ready   operand handshake (a, b, cin, sub)
//   out_valid / out_ready result handshake (sum, co, ovf)
//   sub=0: a+b+cin   sub=1: a-b-cin (co=1 means no borrow); ovf = signed overflow
module chunked_addsub_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Operand registers; b and the carry are pre-inverted for subtract so
    // the RUN datapath is always a plain add (a + ~b + ~cin == a - b - cin).
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry;
    logic [IDXW-1:0]  idx;

    // Current slice arithmetic
    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK-1:0] s_sl;
    logic             c_out;
    logic             c_msb;
    logic             last_slice;

    always_comb begin
        a_sl  = a_r[int'(idx) * CHUNK +: CHUNK];
        b_sl  = b_r[int'(idx) * CHUNK +: CHUNK];
        {c_out, s_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry};
        // Carry into the slice MSB recovered from its sum bit; valid for any
        // CHUNK including 1, where it degenerates to the incoming carry.
        c_msb = s_sl[CHUNK-1] ^ a_sl[CHUNK-1] ^ b_sl[CHUNK-1];
        last_slice = (idx == LAST_IDX);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_slice) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, slice-by-slice accumulation, final flags.
    // Nothing is captured in IDLE unless in_valid is high, so idle inputs
    // never leak into state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            co    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= sub ? ~b : b;
                        carry <= sub ? ~cin : cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    sum[int'(idx) * CHUNK +: CHUNK] <= s_sl;
                    carry <= c_out;
                    if (last_slice) begin
                        idx <= '0;
                        co  <= c_out;
                        ovf <= c_msb ^ c_out;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    // DONE: result registers hold their values
                end
            endcase
        end
    end

endmodule
